// File: rtl/ef_fold_seq.sv
// ef_fold_seq: control sequencer for the folded equalization filter.
// One shared MAC walks every tap per accepted sample, then strobes the output load.
module ef_fold_seq #(
  parameter int TAP_N    = 17,
  parameter int IDX_W    = 5,
  parameter int PIPE_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             shift_o,
  output logic             mac_en_o,
  output logic             mac_first_o,
  output logic [IDX_W-1:0] tap_idx_o,
  output logic             load_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAP_N - 1);
  localparam logic [DW-1:0]    LAST_DRN = DW'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDX_W-1:0] r_tap;
  logic [IDX_W-1:0] w_tap_nx;
  logic [DW-1:0]    r_drn;
  logic [DW-1:0]    w_drn_nx;
  logic             r_ovr;
  logic [CNT_W-1:0] r_drop;

  logic             w_ready;
  logic             w_shift;
  logic             w_mac_en;
  logic             w_first;
  logic [IDX_W-1:0] w_idx;
  logic             w_load;
  logic             w_drop;

  // State and sequence counters; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tap   <= w_tap_nx;
      r_drn   <= w_drn_nx;
    end
  end

  // Next state plus strobes; strobes depend on registered state only,
  // valid_i only steers the next state.
  always_comb begin
    w_state_nx = r_state;
    w_tap_nx   = r_tap;
    w_drn_nx   = r_drn;
    w_ready    = 1'b0;
    w_shift    = 1'b0;
    w_mac_en   = 1'b0;
    w_first    = 1'b0;
    w_idx      = '0;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (valid_i) begin
          w_state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift    = 1'b1;
        w_state_nx = S_MAC;
        w_tap_nx   = '0;
      end
      S_MAC: begin
        w_mac_en = 1'b1;
        w_idx    = r_tap;
        w_first  = (r_tap == '0);
        if (r_tap == LAST_TAP) begin
          w_state_nx = S_DRAIN;
          w_drn_nx   = '0;
        end else begin
          w_tap_nx = r_tap + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_drn == LAST_DRN) begin
          w_load     = 1'b1;
          w_ready    = 1'b1;
          w_state_nx = valid_i ? S_SHIFT : S_IDLE;
        end else begin
          w_drn_nx = r_drn + DW'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // A sample offered while busy is lost; remember it and count it.
  assign w_drop = valid_i & ~w_ready;

  // Sticky overrun flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
      if (r_drop != CNT_MAX) begin
        r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  assign ready_o     = w_ready;
  assign shift_o     = w_shift;
  assign mac_en_o    = w_mac_en;
  assign mac_first_o = w_first;
  assign tap_idx_o   = w_idx;
  assign load_o      = w_load;
  assign overrun_o   = r_ovr;
  assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_ef_fold_seq.sv
// tb_ef_fold_seq: scoreboard bench for the folded filter sequencer.
// Expected strobes are queued per accepted sample and checked by a monitor.
module tb_ef_fold_seq;

  localparam int TAP_N    = 17;
  localparam int IDX_W    = 5;
  localparam int PIPE_LAT = 1;
  localparam int CNT_W    = 8;
  localparam int SEQ      = TAP_N + 1 + PIPE_LAT;
  localparam int EW       = IDX_W + 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic             shift_o;
  logic             mac_en_o;
  logic             mac_first_o;
  logic [IDX_W-1:0] tap_idx_o;
  logic             load_o;
  logic             overrun_o;
  logic [CNT_W-1:0] drop_cnt_o;

  ef_fold_seq #(
    .TAP_N(TAP_N),
    .IDX_W(IDX_W),
    .PIPE_LAT(PIPE_LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .shift_o(shift_o),
    .mac_en_o(mac_en_o),
    .mac_first_o(mac_first_o),
    .tap_idx_o(tap_idx_o),
    .load_o(load_o),
    .overrun_o(overrun_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [EW-1:0] v;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  int  busy_end = 0;
  bit  exp_rdy = 1'b1;
  bit  exp_ovr = 1'b0;
  bit  nxt_ovr = 1'b0;
  int  exp_drop = 0;
  int  nxt_drop = 0;
  int  loads_seen = 0;

  logic [EW-1:0] m_exp;
  logic [EW-1:0] m_act;
  ev_t           m_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] pk(bit sh, bit me, bit mf, int idx, bit ld);
    return {sh, me, mf, IDX_W'(idx), ld};
  endfunction

  function automatic logic [31:0] sat(int d);
    return (d > SAT) ? SAT : d;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(int c, logic [EW-1:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  // One cycle of stimulus; the model decides accept/drop from its own busy window.
  task automatic step(input bit v);
    exp_ovr  = nxt_ovr;
    exp_drop = nxt_drop;
    exp_rdy  = (cyc >= busy_end);
    valid_i  = v;
    if (v && exp_rdy) begin
      push(cyc + 1, pk(1'b1, 1'b0, 1'b0, 0, 1'b0));
      for (int i = 0; i < TAP_N; i++) begin
        push(cyc + 2 + i, pk(1'b0, 1'b1, i == 0, i, 1'b0));
      end
      push(cyc + SEQ, pk(1'b0, 1'b0, 1'b0, 0, 1'b1));
      busy_end = cyc + SEQ;
    end else if (v) begin
      nxt_ovr = 1'b1;
      nxt_drop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_ovr  = nxt_ovr;
    exp_drop = nxt_drop;
    exp_rdy  = (cyc >= busy_end);
    rst      = 1'b1;
    valid_i  = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    busy_end = cyc;
    nxt_ovr  = 1'b0;
    nxt_drop = 0;
    exp_ovr  = 1'b0;
    exp_drop = 0;
    exp_rdy  = 1'b1;
    chk_en   = 1'b1;
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Monitor: every cycle the strobe vector must match the due queue entry (or be idle).
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        m_act = {shift_o, mac_en_o, mac_first_o, tap_idx_o, load_o};
        m_exp = '0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          m_e   = q.pop_front();
          m_exp = m_e.v;
        end
        if (load_o === 1'b1) loads_seen++;
        chk("strobes", m_act, m_exp);
        chk("ready_o", ready_o, exp_rdy);
        chk("overrun_o", overrun_o, exp_ovr);
        chk("drop_cnt_o", drop_cnt_o, sat(exp_drop));
      end
    end
  end

  initial begin
    int l0;
    #1;
    do_reset(2);
    chk("rst_ready", ready_o, 1);
    chk("rst_drop", drop_cnt_o, 0);
    step(1'b0);

    // single sample
    step(1'b1);
    repeat (25) step(1'b0);

    // nominal 20-cycle cadence
    l0 = loads_seen;
    repeat (100) begin
      step(1'b1);
      repeat (19) step(1'b0);
    end
    repeat (5) step(1'b0);
    chk("cadence_loads", loads_seen - l0, 100);
    chk("cadence_ovr", overrun_o, 0);

    // back-to-back at the minimum period
    repeat (10) begin
      step(1'b1);
      repeat (SEQ - 1) step(1'b0);
    end
    repeat (5) step(1'b0);
    chk("b2b_drop", drop_cnt_o, 0);

    // one overrun
    step(1'b1);
    repeat (9) step(1'b0);
    step(1'b1);
    repeat (20) step(1'b0);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_cnt", drop_cnt_o, 1);

    // saturation
    repeat (300) step(1'b1);
    chk("drop_sat", drop_cnt_o, SAT);
    step(1'b0);

    // reset while tap 7 is on the MAC
    do_reset(2);
    step(1'b0);
    step(1'b1);
    repeat (8) step(1'b0);
    chk("pre_rst_tap", tap_idx_o, 7);
    do_reset(2);
    l0 = loads_seen;
    repeat (3) step(1'b0);
    chk("abort_noload", loads_seen - l0, 0);
    step(1'b1);
    repeat (25) step(1'b0);
    chk("clean_load", loads_seen - l0, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if (i < 1500) begin
        step($urandom_range(0, 15) == 0);
      end else begin
        step($urandom_range(0, 2) == 0);
      end
    end
    repeat (SEQ + 5) step(1'b0);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
